// File: rtl/logicnet_lut_loader.sv
// Run-time loadable LogicNet neuron: serial truth-table loader into distributed RAM,
// then one registered lookup per cycle.
module logicnet_lut_loader #(
    parameter int IN_BITS  = 6,
    parameter int OUT_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic [OUT_BITS-1:0] cfg_data,
    output logic                cfg_ready,
    output logic                cfg_done,
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);
    localparam int DEPTH  = 1 << IN_BITS;
    localparam int ADDR_W = IN_BITS + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   addr, addr_nx;
    logic                we;
    logic                done_nx;
    logic [OUT_BITS-1:0] mem [DEPTH];

    always_comb begin
        state_nx  = state;
        addr_nx   = addr;
        we        = 1'b0;
        done_nx   = 1'b0;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start) begin
                    state_nx = LOAD;
                    addr_nx  = '0;
                end
            end
            LOAD: begin
                // A restart takes priority over a beat presented in the same cycle.
                cfg_ready = !cfg_start;
                if (cfg_start) begin
                    addr_nx = '0;
                end else if (cfg_valid) begin
                    we = 1'b1;
                    if (addr == LAST) begin
                        state_nx = RUN;
                        addr_nx  = '0;
                        done_nx  = 1'b1;
                    end else begin
                        addr_nx = addr + ADDR_W'(1);
                    end
                end
            end
            RUN: begin
                in_ready = !cfg_start;
                if (cfg_start) begin
                    state_nx = LOAD;
                    addr_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            cfg_done  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            cfg_done  <= done_nx;
            out_valid <= in_valid && in_ready;
            if (in_valid && in_ready)
                out_data <= mem[in_data];
        end
    end

    // Table contents survive reset; only a completed load makes them meaningful.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr[IN_BITS-1:0]] <= cfg_data;
    end

endmodule

// File: tb/tb_logicnet_lut_loader.sv
// Directed bench for logicnet_lut_loader with a queue-based output scoreboard.
module tb_logicnet_lut_loader;
    localparam int IN_BITS  = 6;
    localparam int OUT_BITS = 2;
    localparam int DEPTH    = 64;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cfg_start = 1'b0;
    logic                cfg_valid = 1'b0;
    logic [OUT_BITS-1:0] cfg_data = '0;
    logic                cfg_ready, cfg_done;
    logic                in_valid = 1'b0;
    logic [IN_BITS-1:0]  in_data = '0;
    logic                in_ready, out_valid;
    logic [OUT_BITS-1:0] out_data;

    always #5 clk = ~clk;

    logicnet_lut_loader #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data)
    );

    typedef struct {
        logic [OUT_BITS-1:0] data;
        int                  tag;
    } exp_t;

    exp_t                sbq[$];
    exp_t                e_m;
    int                  total = 0, bad = 0, cyc = 0, done_cnt = 0;
    bit                  mon_en = 1'b0, use_const = 1'b0;
    logic [OUT_BITS-1:0] const_val = '0;
    logic [OUT_BITS-1:0] exp_tbl [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] pat(input int sel, input int k);
        logic [5:0] a = 6'(k);
        case (sel)
            0:       return a[1:0] ^ a[5:4];
            1:       return a[2:1];
            2:       return 2'b11;
            3:       return ~a[1:0];
            default: return a[5:4];
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: an accept seen at the negedge of cycle c must produce out_valid at cycle c+1.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].tag == cyc - 1) begin
                e_m = sbq.pop_front();
                chk("out_valid", out_valid, 1);
                chk("out_data", out_data, e_m.data);
            end else begin
                chk("out_valid_idle", out_valid, 0);
            end
            if (cfg_done === 1'b1) done_cnt++;
            if (in_valid && in_ready)
                sbq.push_back('{data: (use_const ? const_val : exp_tbl[in_data]), tag: cyc});
        end
    end

    task automatic load(input int sel, input bit tog, input int n);
        int b = 0;
        int guard = 0;
        bit ph = 1'b0;
        int d0 = done_cnt;
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        while (b < n && guard < 300) begin
            @(posedge clk); #1;
            cfg_start = 1'b0;
            cfg_valid = tog ? ph : 1'b1;
            ph        = ~ph;
            cfg_data  = pat(sel, b);
            @(negedge clk);
            if (cfg_valid && cfg_ready) b++;
            guard++;
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        if (guard >= 300) chk("load_timeout", b, n);
        if (n == DEPTH) begin
            @(negedge clk);
            chk("cfg_done_pulse", cfg_done, 1);
            chk("in_ready_after_load", in_ready, 1);
            @(posedge clk); #1;
            @(negedge clk);
            chk("cfg_done_single", cfg_done, 0);
            @(posedge clk); #1;
            chk("done_count", done_cnt, d0 + 1);
            for (int k = 0; k < DEPTH; k++) exp_tbl[k] = pat(sel, k);
        end else begin
            chk("no_done_partial", done_cnt, d0);
        end
    endtask

    task automatic sweep(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 6'(k);
            @(negedge clk);
            chk("in_ready_run", in_ready, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic lookup_const(input logic [5:0] a, input logic [1:0] v);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = a;
        use_const = 1'b1;
        const_val = v;
        @(negedge clk);
        chk("in_ready_const", in_ready, 1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        use_const = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        for (int k = 0; k < DEPTH; k++) exp_tbl[k] = '0;

        // Reset values, sampled while rst is still high
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_cfg_done", cfg_done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: lookups refused while unprogrammed
        in_valid = 1'b1;
        in_data  = '0;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;

        // 2: full load, k[1:0]^k[5:4], then sweep
        load(0, 1'b0, DEPTH);
        sweep(0, DEPTH - 1);
        lookup_const(6'h31, 2'b10);
        lookup_const(6'h00, 2'b00);

        // 3: cfg_valid toggling
        load(1, 1'b1, DEPTH);
        sweep(0, DEPTH - 1);
        lookup_const(6'h3F, 2'b11);
        lookup_const(6'h06, 2'b11);

        // 4: restart after 10 beats, with a beat colliding with the restart
        d0 = done_cnt;
        load(0, 1'b0, 10);
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 2'b00;
        @(negedge clk);
        chk("restart_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        chk("restart_no_done", done_cnt, d0);
        load(2, 1'b0, DEPTH);
        sweep(0, DEPTH - 1);
        lookup_const(6'h2A, 2'b11);

        // 5: cfg_start while lookups stream in RUN
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 6'd5;
            @(negedge clk);
            chk("run_in_ready", in_ready, 1);
        end
        @(posedge clk); #1;
        cfg_start = 1'b1;
        @(negedge clk);
        chk("start_in_ready", in_ready, 0);
        chk("start_cfg_ready", cfg_ready, 0);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("load_in_ready", in_ready, 0);
            chk("load_cfg_ready", cfg_ready, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        load(3, 1'b0, DEPTH);
        sweep(0, DEPTH - 1);
        lookup_const(6'h05, 2'b10);

        // 6: reset in the middle of a load
        load(2, 1'b0, 30);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 6'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_cfg_ready", cfg_ready, 0);
            chk("rst_mid_in_ready", in_ready, 0);
            chk("rst_mid_cfg_done", cfg_done, 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        load(4, 1'b0, DEPTH);
        sweep(0, DEPTH - 1);
        lookup_const(6'h31, 2'b11);

        repeat (3) @(posedge clk);
        #1;
        chk("sbq_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
